// File: rtl/led_write_arb_pkg.sv
// Shared types and constants for the LED write arbiter and its bench.
// Holds the FSM encodings, the requester identifiers and the default post-write hold length.
package led_write_arb_pkg;

   localparam int unsigned HOLD_CYCLES_DEFAULT = 4;
   localparam int unsigned HOLD_CNT_W          = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_PDU = 1'b1
   } requester_e;

endpackage

// File: rtl/led_rr_arb2.sv
// Combinational two-way round-robin picker between the CPU and the debug unit.
// On a tie, the requester that was not granted last wins.
module led_rr_arb2
   import led_write_arb_pkg::*;
(
   input  logic       cpu_req,
   input  logic       pdu_req,
   input  requester_e last_grant,
   output logic       grant_valid,
   output requester_e grant_sel
);

   always_comb begin
      grant_valid = cpu_req | pdu_req;
      grant_sel   = REQ_CPU;
      if (cpu_req && pdu_req)
         grant_sel = (last_grant == REQ_CPU) ? REQ_PDU : REQ_CPU;
      else if (pdu_req)
         grant_sel = REQ_PDU;
   end

endmodule

// File: rtl/led_write_arb.sv
// Arbitrates CPU stores and debug-unit overrides onto the single LED register write port.
// Each write is a one-cycle strobe followed by HOLD_CYCLES idle cycles before the next grant.
module led_write_arb
   import led_write_arb_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [31:0] cpu_data,
   input  logic        pdu_req,
   input  logic [31:0] pdu_data,
   output logic        cpu_ack,
   output logic        pdu_ack,
   output logic        is_led,
   output logic [31:0] led_wdata,
   output logic        busy
);

   localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD =
      (HOLD_CYCLES == 0) ? '0 : HOLD_CNT_W'(HOLD_CYCLES - 1);

   state_e                state_q, state_d;
   logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   requester_e            last_grant_q, last_grant_d;
   requester_e            winner_q, winner_d;
   logic [31:0]           wdata_q, wdata_d;

   logic       grant_valid;
   requester_e grant_sel;

   led_rr_arb2 u_rr (
      .cpu_req     (cpu_req),
      .pdu_req     (pdu_req),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_sel   (grant_sel)
   );

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         hold_cnt_q   <= '0;
         last_grant_q <= REQ_PDU;
         winner_q     <= REQ_CPU;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         last_grant_q <= last_grant_d;
         winner_q     <= winner_d;
         wdata_q      <= wdata_d;
      end
   end

   // NOTE: every signal gets a default first so no path leaves a value unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      last_grant_d = last_grant_q;
      winner_d     = winner_q;
      wdata_d      = wdata_q;
      is_led       = 1'b0;
      cpu_ack      = 1'b0;
      pdu_ack      = 1'b0;
      busy         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               winner_d = grant_sel;
               wdata_d  = (grant_sel == REQ_PDU) ? pdu_data : cpu_data;
               state_d  = ST_GRANT;
            end
         end
         ST_GRANT: begin
            is_led       = 1'b1;
            busy         = 1'b1;
            cpu_ack      = (winner_q == REQ_CPU);
            pdu_ack      = (winner_q == REQ_PDU);
            last_grant_d = winner_q;
            if (HOLD_CYCLES == 0) begin
               state_d = ST_IDLE;
            end else begin
               hold_cnt_d = HOLD_LOAD;
               state_d    = ST_HOLD;
            end
         end
         ST_HOLD: begin
            busy = 1'b1;
            // Counter parks at zero; the exit edge is the one where it reads zero.
            if (hold_cnt_q == '0)
               state_d = ST_IDLE;
            else
               hold_cnt_d = hold_cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign led_wdata = wdata_q;

endmodule

// File: tb/tb_led_write_arb.sv
// Directed self-checking bench for led_write_arb: default hold length plus a zero-hold instance.
// Inputs change 1 time unit after the rising edge, which is also when outputs are compared.
module tb_led_write_arb;
   import led_write_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0, pdu_req = 1'b0;
   logic [31:0] cpu_data = '0, pdu_data = '0;
   logic        cpu_ack, pdu_ack, is_led, busy;
   logic [31:0] led_wdata;

   logic        cpu_req0 = 1'b0;
   logic [31:0] cpu_data0 = '0;
   logic        cpu_ack0, pdu_ack0, is_led0, busy0;
   logic [31:0] led_wdata0;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   led_write_arb #(.HOLD_CYCLES(HOLD_CYCLES_DEFAULT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_data  (cpu_data),
      .pdu_req   (pdu_req),
      .pdu_data  (pdu_data),
      .cpu_ack   (cpu_ack),
      .pdu_ack   (pdu_ack),
      .is_led    (is_led),
      .led_wdata (led_wdata),
      .busy      (busy)
   );

   led_write_arb #(.HOLD_CYCLES(0)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req0),
      .cpu_data  (cpu_data0),
      .pdu_req   (1'b0),
      .pdu_data  (32'h0),
      .cpu_ack   (cpu_ack0),
      .pdu_ack   (pdu_ack0),
      .is_led    (is_led0),
      .led_wdata (led_wdata0),
      .busy      (busy0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 50) begin
         tick();
         n++;
      end
      check("wait_idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #1;
      check("rst_is_led", 32'(is_led), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_acks", {30'd0, cpu_ack, pdu_ack}, 32'd0);
      check("rst_wdata", led_wdata, 32'h0);
      check("rst0_is_led", 32'(is_led0), 32'd0);
      tick(); tick();

      // Single CPU write; request presented in the same step as reset release
      rst      = 1'b0;
      cpu_req  = 1'b1;
      cpu_data = 32'h0000_A5A5;
      tick();
      check("cpu1_is_led", 32'(is_led), 32'd1);
      check("cpu1_cpu_ack", 32'(cpu_ack), 32'd1);
      check("cpu1_pdu_ack", 32'(pdu_ack), 32'd0);
      check("cpu1_wdata", led_wdata, 32'h0000_A5A5);
      check("cpu1_busy", 32'(busy), 32'd1);
      cpu_req = 1'b0;
      for (int c = 2; c <= 6; c++) begin
         tick();
         check($sformatf("cpu1_busy_c%0d", c), 32'(busy), (c <= 5) ? 32'd1 : 32'd0);
         check($sformatf("cpu1_is_led_c%0d", c), 32'(is_led), 32'd0);
      end
      check("cpu1_wdata_kept", led_wdata, 32'h0000_A5A5);

      // Simultaneous requests after reset: CPU, PDU, CPU at cycles 1, 7, 13
      rst = 1'b1;
      #2 rst = 1'b0;
      cpu_req  = 1'b1; cpu_data = 32'h1111;
      pdu_req  = 1'b1; pdu_data = 32'h2222;
      for (int c = 1; c <= 13; c++) begin
         tick();
         check($sformatf("tie_is_led_c%0d", c), 32'(is_led), (c == 1 || c == 7 || c == 13) ? 32'd1 : 32'd0);
         check($sformatf("tie_cpu_ack_c%0d", c), 32'(cpu_ack), (c == 1 || c == 13) ? 32'd1 : 32'd0);
         check($sformatf("tie_pdu_ack_c%0d", c), 32'(pdu_ack), (c == 7) ? 32'd1 : 32'd0);
         if (c == 1 || c == 13) check($sformatf("tie_wdata_c%0d", c), led_wdata, 32'h1111);
         if (c == 7) check("tie_wdata_c7", led_wdata, 32'h2222);
      end
      cpu_req = 1'b0;
      pdu_req = 1'b0;
      wait_idle();

      // PDU request raised during HOLD is serviced at cycle 7
      cpu_req = 1'b1; cpu_data = 32'hCAFE_0001;
      tick();
      check("hold_cpu_ack", 32'(cpu_ack), 32'd1);
      cpu_req = 1'b0;
      tick(); tick();
      pdu_req = 1'b1; pdu_data = 32'h3333;
      for (int c = 3; c <= 7; c++) begin
         if (c > 3) tick();
         check($sformatf("hold_pdu_ack_c%0d", c), 32'(pdu_ack), (c == 7) ? 32'd1 : 32'd0);
         check($sformatf("hold_is_led_c%0d", c), 32'(is_led), (c == 7) ? 32'd1 : 32'd0);
      end
      check("hold_wdata", led_wdata, 32'h3333);
      pdu_req = 1'b0;
      wait_idle();

      // Reset mid-HOLD aborts and clears everything immediately
      cpu_req = 1'b1; cpu_data = 32'h4444;
      tick();
      check("rsth_ack", 32'(cpu_ack), 32'd1);
      cpu_req = 1'b0;
      tick(); tick();
      check("rsth_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("rsth_busy", 32'(busy), 32'd0);
      check("rsth_wdata", led_wdata, 32'h0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         check($sformatf("rsth_no_led_c%0d", c), 32'(is_led), 32'd0);
      end

      // Request raised and dropped between edges produces nothing
      #1 cpu_req = 1'b1; cpu_data = 32'hDEAD_BEEF;
      #2 cpu_req = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("wd_is_led_c%0d", c), 32'(is_led), 32'd0);
         check($sformatf("wd_cpu_ack_c%0d", c), 32'(cpu_ack), 32'd0);
      end
      check("wd_wdata", led_wdata, 32'h0);

      // Zero hold length: continuous request strobes every other cycle
      cpu_req0 = 1'b1; cpu_data0 = 32'h0000_5A5A;
      for (int c = 1; c <= 8; c++) begin
         tick();
         check($sformatf("h0_is_led_c%0d", c), 32'(is_led0), (c % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("h0_cpu_ack_c%0d", c), 32'(cpu_ack0), (c % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("h0_busy_c%0d", c), 32'(busy0), (c % 2 == 1) ? 32'd1 : 32'd0);
      end
      check("h0_wdata", led_wdata0, 32'h0000_5A5A);
      cpu_req0 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/led_write_arb.md
LED_WRITE_ARB -- requirements
Module: led_write_arb

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, meaning: minimum idle cycles after each LED write before the next grant; legal range 0..2^24-1.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU store-to-LED request; level, held until cpu_ack.
REQ-005 cpu_data  input  32  CPU write data (busB value); stable while cpu_req=1.
REQ-006 pdu_req  input  1  debug-unit (PDU) LED override request; level, held until pdu_ack.
REQ-007 pdu_data  input  32  PDU write data; stable while pdu_req=1.
REQ-008 cpu_ack  output  1  one-cycle pulse: CPU write accepted and issued.
REQ-009 pdu_ack  output  1  one-cycle pulse: PDU write accepted and issued.
REQ-010 is_led  output  1  one-cycle write strobe to the LED register.
REQ-011 led_wdata  output  32  data presented with is_led; the LED register takes bits [15:0].
REQ-012 busy  output  1  high in GRANT and HOLD states.

Function
REQ-013 The FSM SHALL have three states: IDLE, GRANT and HOLD, all held in registered state.
REQ-014 In IDLE with no request, the block SHALL stay in IDLE, with all outputs 0 and led_wdata unchanged.
REQ-015 In IDLE with at least one request sampled, the block SHALL pick a winner, capture that requester's data into led_wdata, and go to GRANT on the next edge.
REQ-016 Arbitration SHALL be two-way round-robin.
- With a single requester, that requester wins.
- With both requesting, the requester not granted last wins.
- After reset, the CPU has priority.
REQ-017 In GRANT, the block SHALL drive is_led=1, drive the winner's ack=1 and the loser's ack=0, for exactly one cycle.
REQ-018 Write latency: is_led and ack SHALL assert exactly 1 cycle after the request is first sampled in IDLE.
REQ-019 GRANT exit:
- If HOLD_CYCLES=0, GRANT SHALL go to IDLE.
- Otherwise, GRANT SHALL go to HOLD and load hold_cnt=HOLD_CYCLES-1.
REQ-020 In HOLD, the block SHALL decrement hold_cnt each cycle and go to IDLE on the edge where hold_cnt=0; total HOLD dwell = HOLD_CYCLES cycles.
REQ-021 Requests SHALL be ignored, and not acked, in GRANT and HOLD; they are serviced on return to IDLE.
REQ-022 A request dropped while in IDLE before capture SHALL cause no write.
- Once captured, the write SHALL complete regardless of req.
REQ-023 A req still high in the cycle after its ack SHALL be treated as a new request.
- The requester must drop req in the ack cycle to avoid a duplicate write.
REQ-024 Throughput limit: one write per (2+HOLD_CYCLES) cycles.
- Continuous requests from both sides SHALL alternate CPU, PDU, CPU, ...
REQ-025 hold_cnt SHALL be 24 bits wide and never wrap; the decrement is gated at 0.
REQ-026 The last-grant pointer SHALL update only in GRANT.

Reset
REQ-027 On rst=1, asynchronously:
- state=IDLE, hold_cnt=0, last_grant=PDU (so CPU wins the first tie).
- is_led=0, cpu_ack=0, pdu_ack=0, busy=0, led_wdata=32'h0.
REQ-028 Reset asserted mid-GRANT or mid-HOLD SHALL abort the sequence; no strobe follows reset release until a fresh request is sampled.
REQ-029 After rst deasserts, the first request SHALL be sampled on the first clk edge.

Structure
REQ-030 State encodings (IDLE=2'd0, GRANT=2'd1, HOLD=2'd2) and the default HOLD_CYCLES SHALL live in a shared header included by this block and the bench.
REQ-031 One sub-module SHALL be used: led_rr_arb2, a combinational 2-way round-robin picker.
- Inputs: cpu_req, pdu_req, last_grant.
- Outputs: grant_valid, grant_sel.
REQ-032 The LED register module SHALL connect is_led→is_led and led_wdata→busB unchanged.

Verification (HOLD_CYCLES=4)
REQ-033 Single CPU write:
- Stimulus: cpu_req=1, cpu_data=32'h0000_A5A5 at cycle 0, dropped on ack.
- Response: is_led=1 and cpu_ack=1 at cycle 1, led_wdata=32'h0000_A5A5, busy high cycles 1-5, IDLE at cycle 6.
REQ-034 Simultaneous requests after reset:
- Stimulus: cpu_data=32'h1111, pdu_data=32'h2222, both reqs held.
- Response: CPU granted at cycle 1, PDU granted at cycle 7, strobe data 32'h1111 then 32'h2222.
REQ-035 Request during HOLD:
- Stimulus: pdu_req raised at cycle 3 after a CPU grant at cycle 1.
- Response: no pdu_ack before cycle 7; pdu_ack and is_led at cycle 7.
REQ-036 Reset mid-HOLD:
- Stimulus: rst pulsed at cycle 3 after a cycle-1 grant.
- Response: busy=0 and led_wdata=0 immediately; no is_led until a new request.
REQ-037 HOLD_CYCLES=0 with cpu_req held continuously:
- Response: is_led pulses every 2 cycles.
REQ-038 Withdrawn request:
- Stimulus: cpu_req high for 0 sampled edges (raised and dropped between edges).
- Response: no is_led, no cpu_ack.
